// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for a 5-stage RV32I core: per-stage valid tracking, register enables,
// PC redirect select, data-memory request and a saturating lost-cycle counter.
module pipe_hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              imem_ready,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_regwr,
   input  logic              ex_isload,
   input  logic              ex_memop,
   input  logic              ex_redirect,
   input  logic              dmem_ready,
   output logic              if_en,
   output logic              id_en,
   output logic              ex_en,
   output logic              mem_en,
   output logic              pc_sel,
   output logic              id_valid,
   output logic              ex_valid,
   output logic              mem_valid,
   output logic              wb_valid,
   output logic              dmem_req,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic             id_valid_q,  id_valid_d;
   logic             ex_valid_q,  ex_valid_d;
   logic             mem_valid_q, mem_valid_d;
   logic             wb_valid_q,  wb_valid_d;
   logic             mem_memop_q, mem_memop_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic mem_stall;
   logic redirect;
   logic src_match;
   logic lu_hazard;

   // Hazard terms in priority order: a memory stall freezes everything, a redirect
   // squashes the younger instructions, and only then is a load-use bubble considered.
   assign mem_stall = mem_valid_q & mem_memop_q & ~dmem_ready;
   assign redirect  = ex_valid_q & ex_redirect & ~mem_stall;
   assign src_match = (id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd));
   assign lu_hazard = id_valid_q & ex_valid_q & ex_isload & ex_regwr & (ex_rd != '0) &
                      src_match & ~mem_stall & ~redirect;

   assign dmem_req = mem_valid_q & mem_memop_q;
   assign pc_sel   = redirect;

   always_comb begin
      if_en       = 1'b0;
      id_en       = 1'b0;
      ex_en       = 1'b0;
      mem_en      = 1'b0;
      id_valid_d  = id_valid_q;
      ex_valid_d  = ex_valid_q;
      mem_valid_d = mem_valid_q;
      wb_valid_d  = 1'b0;
      mem_memop_d = mem_memop_q;
      if (!mem_stall) begin
         mem_en      = 1'b1;
         ex_en       = 1'b1;
         wb_valid_d  = mem_valid_q;
         mem_valid_d = ex_valid_q;
         mem_memop_d = ex_valid_q & ex_memop;
         if (redirect) begin
            if_en      = 1'b1;
            id_en      = 1'b1;
            id_valid_d = 1'b0;
            ex_valid_d = 1'b0;
         end else if (lu_hazard) begin
            ex_valid_d = 1'b0;
         end else begin
            ex_valid_d = id_valid_q;
            id_en      = 1'b1;
            if_en      = imem_ready;
            id_valid_d = imem_ready;
         end
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if ((mem_stall | lu_hazard) && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         id_valid_q  <= 1'b0;
         ex_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         wb_valid_q  <= 1'b0;
         mem_memop_q <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         id_valid_q  <= id_valid_d;
         ex_valid_q  <= ex_valid_d;
         mem_valid_q <= mem_valid_d;
         wb_valid_q  <= wb_valid_d;
         mem_memop_q <= mem_memop_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign id_valid  = id_valid_q;
   assign ex_valid  = ex_valid_q;
   assign mem_valid = mem_valid_q;
   assign wb_valid  = wb_valid_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios plus random traffic, compared against
// a token-tracking pipeline model; a second instance with a 4-bit counter checks saturation.
module tb_pipe_hazard_ctrl;

   localparam int ID = 0, EX = 1, MEM = 2, WB = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       imem_ready, id_use_rs1, id_use_rs2, ex_regwr, ex_isload, ex_memop;
   logic       ex_redirect, dmem_ready;
   logic [4:0] id_rs1, id_rs2, ex_rd;
   logic       if_en, id_en, ex_en, mem_en, pc_sel, id_valid, ex_valid, mem_valid, wb_valid, dmem_req;
   logic [15:0] stall_cnt;
   logic       s_if_en, s_id_en, s_ex_en, s_mem_en, s_pc_sel, s_id_valid, s_ex_valid;
   logic       s_mem_valid, s_wb_valid, s_dmem_req;
   logic [3:0] s_stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Model: each stage holds an instruction token (0 = bubble); the MEM slot remembers memop.
   int pipe[4];
   bit mop;
   int cnt;
   int next_tok;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_isload(ex_isload), .ex_memop(ex_memop),
      .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
      .if_en(if_en), .id_en(id_en), .ex_en(ex_en), .mem_en(mem_en), .pc_sel(pc_sel),
      .id_valid(id_valid), .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
      .dmem_req(dmem_req), .stall_cnt(stall_cnt)
   );

   pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(4)) dut_small (
      .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_isload(ex_isload), .ex_memop(ex_memop),
      .ex_redirect(ex_redirect), .dmem_ready(dmem_ready),
      .if_en(s_if_en), .id_en(s_id_en), .ex_en(s_ex_en), .mem_en(s_mem_en), .pc_sel(s_pc_sel),
      .id_valid(s_id_valid), .ex_valid(s_ex_valid), .mem_valid(s_mem_valid),
      .wb_valid(s_wb_valid), .dmem_req(s_dmem_req), .stall_cnt(s_stall_cnt)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic set_defaults();
      imem_ready = 1'b1; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_rd = '0; ex_regwr = 1'b0; ex_isload = 1'b0; ex_memop = 1'b0;
      ex_redirect = 1'b0; dmem_ready = 1'b1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) pipe[i] = 0;
      mop = 1'b0;
      cnt = 0;
   endtask

   task automatic check_regs(input string tag);
      check({tag, ".id_valid"},  int'(id_valid),  int'(pipe[ID]  != 0));
      check({tag, ".ex_valid"},  int'(ex_valid),  int'(pipe[EX]  != 0));
      check({tag, ".mem_valid"}, int'(mem_valid), int'(pipe[MEM] != 0));
      check({tag, ".wb_valid"},  int'(wb_valid),  int'(pipe[WB]  != 0));
      check({tag, ".stall_cnt"}, int'(stall_cnt), (cnt > 65535) ? 65535 : cnt);
      check({tag, ".stall_cnt4"}, int'(s_stall_cnt), (cnt > 15) ? 15 : cnt);
   endtask

   // Reset is asserted away from any clock edge, so it must take effect on its own.
   task automatic do_reset(input string tag);
      set_defaults();
      #2 rst_n = 1'b0;
      #1;
      model_clear();
      check_regs({tag, ".rst"});
      check({tag, ".rst.dmem_req"}, int'(dmem_req), 0);
      check({tag, ".rst.pc_sel"},   int'(pc_sel),   0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One clock cycle with the inputs already driven; entered and left at a falling edge.
   task automatic tick(input string tag);
      bit ms, rd, lu, reads;
      #1;
      reads = (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
      ms = pipe[MEM] != 0 && mop && !dmem_ready;
      rd = !ms && pipe[EX] != 0 && ex_redirect;
      lu = !ms && !rd && pipe[ID] != 0 && pipe[EX] != 0 && ex_isload && ex_regwr &&
           ex_rd != 0 && reads;
      check({tag, ".mem_en"},   int'(mem_en),   int'(!ms));
      check({tag, ".ex_en"},    int'(ex_en),    int'(!ms));
      check({tag, ".id_en"},    int'(id_en),    int'(!ms && !lu));
      check({tag, ".if_en"},    int'(if_en),    int'(!ms && (rd || (!lu && imem_ready))));
      check({tag, ".pc_sel"},   int'(pc_sel),   int'(rd));
      check({tag, ".dmem_req"}, int'(dmem_req), int'(pipe[MEM] != 0 && mop));
      @(posedge clk);
      if (ms) begin
         pipe[WB] = 0;
      end else begin
         pipe[WB]  = pipe[MEM];
         pipe[MEM] = pipe[EX];
         mop       = pipe[EX] != 0 && ex_memop;
         if (rd) begin
            pipe[EX] = 0;
            pipe[ID] = 0;
         end else if (lu) begin
            pipe[EX] = 0;
         end else begin
            pipe[EX] = pipe[ID];
            if (imem_ready) begin
               pipe[ID] = next_tok;
               next_tok++;
            end else begin
               pipe[ID] = 0;
            end
         end
      end
      if (ms || lu) cnt++;
      #1;
      check_regs(tag);
      $display("%s: ms=%0b rd=%0b lu=%0b stages=%0d/%0d/%0d/%0d cnt=%0d", tag, ms, rd, lu,
               pipe[ID], pipe[EX], pipe[MEM], pipe[WB], stall_cnt);
      @(negedge clk);
   endtask

   task automatic load_in_ex();
      ex_memop = 1'b1; ex_isload = 1'b1; ex_regwr = 1'b1; ex_rd = 5'd5;
   endtask

   initial begin
      next_tok = 1;
      set_defaults();
      @(negedge clk);

      // Pipeline fill with steady fetch
      do_reset("fill");
      for (int i = 0; i < 4; i++) tick("fill");
      check("fill.wb_full", int'(wb_valid), 1);
      check("fill.no_stall", int'(stall_cnt), 0);

      // Load-use on rs1: one bubble, then ID reissues
      do_reset("lu");
      tick("lu"); tick("lu");
      load_in_ex(); id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      tick("lu");
      check("lu.bubble", int'(ex_valid), 0);
      check("lu.cnt", int'(stall_cnt), 1);
      set_defaults();
      tick("lu");
      check("lu.reissue", int'(ex_valid), 1);

      // rd=x0 and a store in EX never bubble
      do_reset("nolu");
      tick("nolu"); tick("nolu");
      load_in_ex(); ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
      tick("nolu");
      set_defaults();
      ex_memop = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
      tick("nolu");
      check("nolu.ex_valid", int'(ex_valid), 1);
      check("nolu.cnt", int'(stall_cnt), 0);

      // Redirect beats a simultaneous load-use
      do_reset("redir");
      tick("redir"); tick("redir");
      load_in_ex(); id_rs1 = 5'd5; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
      tick("redir");
      check("redir.id_flush", int'(id_valid), 0);
      check("redir.ex_flush", int'(ex_valid), 0);
      check("redir.cnt", int'(stall_cnt), 0);

      // Load waits three cycles in MEM
      do_reset("dwait");
      tick("dwait"); tick("dwait");
      load_in_ex();
      tick("dwait");
      set_defaults(); dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) tick("dwait");
      check("dwait.wb_idle", int'(wb_valid), 0);
      dmem_ready = 1'b1;
      tick("dwait");
      check("dwait.wb_done", int'(wb_valid), 1);
      check("dwait.cnt", int'(stall_cnt), 3);

      // Long stall saturates the narrow counter; reset mid-stall clears at once
      do_reset("sat");
      tick("sat"); tick("sat");
      load_in_ex();
      tick("sat");
      set_defaults(); dmem_ready = 1'b0;
      for (int i = 0; i < 20; i++) tick("sat");
      check("sat.cnt16", int'(stall_cnt), 20);
      check("sat.cnt4", int'(s_stall_cnt), 15);
      check("sat.req_held", int'(dmem_req), 1);
      #2 rst_n = 1'b0;
      #1;
      check("sat.rst_cnt", int'(stall_cnt), 0);
      check("sat.rst_cnt4", int'(s_stall_cnt), 0);
      check("sat.rst_req", int'(dmem_req), 0);
      model_clear();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic against the model
      do_reset("rand");
      for (int i = 0; i < 400; i++) begin
         imem_ready  = ($urandom_range(0, 3) != 0);
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_use_rs1  = 1'($urandom_range(0, 1));
         id_use_rs2  = 1'($urandom_range(0, 1));
         ex_rd       = 5'($urandom_range(0, 3));
         ex_regwr    = 1'($urandom_range(0, 1));
         ex_isload   = 1'($urandom_range(0, 1));
         ex_memop    = ex_isload | 1'($urandom_range(0, 1));
         ex_redirect = ($urandom_range(0, 7) == 0);
         dmem_ready  = ($urandom_range(0, 3) != 0);
         tick("rand");
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
